// File: rtl/param_sync_fifo.sv
// Parameterised synchronous FIFO with occupancy count, almost flags and sticky errors.
// Supports any DEPTH >= 2 and either a registered read port or first-word-fall-through.
module param_sync_fifo #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         w_ptr;
  logic [PW-1:0]         r_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Status is decoded purely from the count register, so every flag lags its cause by one edge.
  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (int'(count) >= AF_LEVEL);
  assign almost_empty = (int'(count) <= AE_LEVEL);

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[w_ptr] <= data_in;
    end
  end

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths use every slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
    end else begin
      if (wr_acc) begin
        w_ptr <= (w_ptr == LAST_PTR) ? '0 : w_ptr + 1'b1;
      end
      if (rd_acc) begin
        r_ptr <= (r_ptr == LAST_PTR) ? '0 : r_ptr + 1'b1;
      end
      if (wr_acc && !rd_acc) begin
        count <= count + 1'b1;
      end else if (rd_acc && !wr_acc) begin
        count <= count - 1'b1;
      end
    end
  end

  // A new error in the clearing cycle wins over err_clr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow && !err_clr) || (wr_en && full);
      underflow <= (underflow && !err_clr) || (rd_en && empty);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = empty ? '0 : mem[r_ptr];
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          data_out <= '0;
        end else if (rd_acc) begin
          data_out <= mem[r_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench: a registered-read DEPTH=5 FIFO and a FWFT DEPTH=16 FIFO share one stimulus
// stream and are compared every cycle against a queue-based reference model.
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic [7:0] dout_a, dout_b;
  logic       full_a, empty_a, af_a, ae_a, ov_a, ud_a;
  logic       full_b, empty_b, af_b, ae_b, ov_b, ud_b;
  logic [2:0] count_a;
  logic [4:0] count_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  param_sync_fifo #(.DEPTH(5), .DATA_WIDTH(8), .FWFT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .err_clr(err_clr), .data_out(dout_a), .full(full_a), .empty(empty_a),
    .almost_full(af_a), .almost_empty(ae_a), .count(count_a),
    .overflow(ov_a), .underflow(ud_a)
  );

  param_sync_fifo #(.DEPTH(16), .DATA_WIDTH(8), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .err_clr(err_clr), .data_out(dout_b), .full(full_b), .empty(empty_b),
    .almost_full(af_b), .almost_empty(ae_b), .count(count_b),
    .overflow(ov_b), .underflow(ud_b)
  );

  // Reference model: instance 0 is dut_a, instance 1 is dut_b.
  int         m_depth [2] = '{5, 16};
  int         m_af    [2] = '{3, 14};
  int         m_ae    [2] = '{2, 2};
  int         m_fwft  [2] = '{0, 1};
  logic [7:0] mq      [2][$];
  logic       m_ov    [2];
  logic       m_ud    [2];
  logic [7:0] m_dout  [2];

  typedef struct {
    logic       wr;
    logic       rd;
    logic       clr;
    logic [7:0] din;
    int         cnt;
    logic [7:0] dout;
    logic       ov;
    logic       ud;
  } vec_t;

  vec_t vecs [28];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mq[i].delete();
        m_ov[i]   = 1'b0;
        m_ud[i]   = 1'b0;
        m_dout[i] = 8'h00;
      end else begin
        bit is_full, is_empty;
        is_full  = (mq[i].size() == m_depth[i]);
        is_empty = (mq[i].size() == 0);
        m_ov[i] = (m_ov[i] && !err_clr) || (wr_en && is_full);
        m_ud[i] = (m_ud[i] && !err_clr) || (rd_en && is_empty);
        if (rd_en && !is_empty) m_dout[i] = mq[i].pop_front();
        if (wr_en && !is_full) mq[i].push_back(data_in);
      end
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic clr, input logic [7:0] din);
    wr_en   = wr;
    rd_en   = rd;
    err_clr = clr;
    data_in = din;
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 2; i++) begin
      int         sz;
      string      p;
      logic [31:0] a_cnt;
      logic       a_full, a_empty, a_af, a_ae, a_ov, a_ud;
      logic [7:0] a_dout;
      sz = mq[i].size();
      p  = (i == 0) ? "a" : "b";
      a_cnt   = (i == 0) ? 32'(count_a) : 32'(count_b);
      a_full  = (i == 0) ? full_a  : full_b;
      a_empty = (i == 0) ? empty_a : empty_b;
      a_af    = (i == 0) ? af_a    : af_b;
      a_ae    = (i == 0) ? ae_a    : ae_b;
      a_ov    = (i == 0) ? ov_a    : ov_b;
      a_ud    = (i == 0) ? ud_a    : ud_b;
      a_dout  = (i == 0) ? dout_a  : dout_b;
      checkVal({"count_", p}, a_cnt, sz);
      checkVal({"full_", p}, 32'(a_full), 32'(sz == m_depth[i]));
      checkVal({"empty_", p}, 32'(a_empty), 32'(sz == 0));
      checkVal({"almost_full_", p}, 32'(a_af), 32'(sz >= m_af[i]));
      checkVal({"almost_empty_", p}, 32'(a_ae), 32'(sz <= m_ae[i]));
      checkVal({"overflow_", p}, 32'(a_ov), 32'(m_ov[i]));
      checkVal({"underflow_", p}, 32'(a_ud), 32'(m_ud[i]));
      if (m_fwft[i] == 0) checkVal({"data_out_", p}, 32'(a_dout), 32'(m_dout[i]));
      else if (sz != 0)   checkVal({"data_out_", p}, 32'(a_dout), 32'(mq[i][0]));
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h11, 1, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h22, 2, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h33, 3, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h44, 4, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h55, 5, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h66, 5, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 4, 8'h11, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 3, 8'h22, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 2, 8'h33, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 8'h44, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h55, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'h55, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'h55, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 8'hA1, 1, 8'h55, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 8'hA2, 2, 8'h55, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 8'hA3, 3, 8'h55, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 8'hA4, 4, 8'h55, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 8'hA5, 5, 8'h55, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 8'hB6, 4, 8'hA1, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 8'h00, 3, 8'hA2, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 1'b0, 8'h00, 2, 8'hA3, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 8'h00, 1, 8'hA4, 1'b1, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'hA5, 1'b1, 1'b0};
    vecs[23] = '{1'b1, 1'b1, 1'b0, 8'hC7, 1, 8'hA5, 1'b1, 1'b1};
    vecs[24] = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 8'hA5, 1'b0, 1'b0};
    vecs[25] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 8'hC7, 1'b0, 1'b0};
    vecs[26] = '{1'b0, 1'b1, 1'b1, 8'h00, 0, 8'hC7, 1'b0, 1'b1};
    vecs[27] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 8'hC7, 1'b0, 1'b0};

    // Reset state
    doReset();
    checkVal("reset_count_a", 32'(count_a), 0);
    checkVal("reset_empty_a", 32'(empty_a), 1);
    checkVal("reset_full_a", 32'(full_a), 0);
    checkVal("reset_dout_a", 32'(dout_a), 0);
    checkVal("reset_empty_b", 32'(empty_b), 1);
    checkOutput();

    // Directed table on the DEPTH=5 registered-read FIFO
    for (int v = 0; v < 28; v++) begin
      applyStimulus(vecs[v].wr, vecs[v].rd, vecs[v].clr, vecs[v].din);
      checkVal($sformatf("vec%0d_count_a", v), 32'(count_a), vecs[v].cnt);
      checkVal($sformatf("vec%0d_dout_a", v), 32'(dout_a), 32'(vecs[v].dout));
      checkVal($sformatf("vec%0d_ov_a", v), 32'(ov_a), 32'(vecs[v].ov));
      checkVal($sformatf("vec%0d_ud_a", v), 32'(ud_a), 32'(vecs[v].ud));
      checkOutput();
    end

    // Pointer wrap on DEPTH=5: 3 in, 3 out, four rounds
    doReset();
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) begin
        applyStimulus(1'b1, 1'b0, 1'b0, 8'((r << 4) | (k + 1)));
        checkOutput();
      end
      for (int k = 0; k < 3; k++) begin
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        checkVal("wrap_dout_a", 32'(dout_a), 32'((r << 4) | (k + 1)));
        checkOutput();
      end
    end
    checkVal("wrap_final_count_a", 32'(count_a), 0);

    // Almost-flag thresholds on the DEPTH=16 FIFO
    doReset();
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'(k));
      checkVal("fill_count_b", 32'(count_b), k);
      checkVal("fill_af_b", 32'(af_b), 32'(k >= 14));
      checkVal("fill_ae_b", 32'(ae_b), 32'(k <= 2));
      checkVal("fill_full_b", 32'(full_b), 32'(k == 16));
      checkOutput();
    end

    // FWFT: first word visible without a read
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hA5);
    checkVal("fwft_empty_b", 32'(empty_b), 0);
    checkVal("fwft_dout_b", 32'(dout_b), 32'h A5);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkVal("fwft_pop_empty_b", 32'(empty_b), 1);
    checkOutput();

    // Mid-operation reset discards contents
    doReset();
    for (int k = 0; k < 7; k++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h70 + k));
    checkVal("pre_rst_count_b", 32'(count_b), 7);
    doReset();
    checkVal("mid_rst_count_a", 32'(count_a), 0);
    checkVal("mid_rst_count_b", 32'(count_b), 0);
    checkVal("mid_rst_empty_a", 32'(empty_a), 1);
    checkVal("mid_rst_dout_a", 32'(dout_a), 0);
    checkVal("mid_rst_ov_a", 32'(ov_a), 0);
    checkVal("mid_rst_ud_a", 32'(ud_a), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h3C);
    checkVal("post_rst_dout_b", 32'(dout_b), 32'h3C);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    checkVal("post_rst_dout_a", 32'(dout_a), 32'h3C);
    checkVal("post_rst_count_a", 32'(count_a), 0);
    checkOutput();

    // Randomised traffic with drifting write/read bias
    doReset();
    for (int c = 0; c < 3000; c++) begin
      int wp;
      wp = ((c / 200) % 2 == 0) ? 70 : 30;
      if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      applyStimulus(1'($urandom_range(0, 99) < wp), 1'($urandom_range(0, 99) < (100 - wp)),
                    1'($urandom_range(0, 19) == 0), 8'($urandom));
      rst_n = 1'b1;
      checkOutput();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
